// File: rtl/vga_char_scanner.sv
// vga_char_scanner: 640x480 VGA timing, character memory addressing and pixel-aligned glyph outputs
module vga_char_scanner #(
   parameter int CLK_DIV   = 4,
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic        clk,
   input  logic        rst,
   output logic [11:0] char_addr,
   input  logic [7:0]  char_data,
   output logic        pix_stb,
   output logic [7:0]  char_code,
   output logic [3:0]  glyph_row,
   output logic [2:0]  glyph_col,
   output logic        blank,
   output logic        hsync,
   output logic        vsync,
   output logic        frame_start
);
   localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
   localparam logic [9:0] HS_LO  = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_HI  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_LO  = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_HI  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic [DW-1:0] div_q, div_d;
   logic [9:0]    h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [9:0]    hc_q, hc_d, vc_q, vc_d;
   logic [7:0]    data_q, data_d, code_q, code_d;
   logic [3:0]    row_q, row_d;
   logic [2:0]    col_q, col_d;
   logic          stb_q, stb_d, blank_q, blank_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
   logic          pix_en, h_wrap, v_wrap;

   assign char_addr   = {v_cnt_q[8:4], h_cnt_q[9:3]};
   assign pix_stb     = stb_q;
   assign char_code   = code_q;
   assign glyph_row   = row_q;
   assign glyph_col   = col_q;
   assign blank       = blank_q;
   assign hsync       = hs_q;
   assign vsync       = vs_q;
   assign frame_start = fs_q;

   // divider, raster counters, memory-return capture and per-pixel output update
   always_comb begin
      pix_en  = div_q == D_LAST;
      h_wrap  = h_cnt_q == H_LAST;
      v_wrap  = v_cnt_q == V_LAST;
      div_d   = pix_en ? '0 : div_q + 1'b1;
      h_cnt_d = !pix_en ? h_cnt_q : h_wrap ? '0 : h_cnt_q + 1'b1;
      v_cnt_d = !(pix_en && h_wrap) ? v_cnt_q : v_wrap ? '0 : v_cnt_q + 1'b1;
      data_d  = char_data;
      hc_d    = h_cnt_q;
      vc_d    = v_cnt_q;
      stb_d   = pix_en;
      code_d  = pix_en ? data_q : code_q;
      row_d   = pix_en ? vc_q[3:0] : row_q;
      col_d   = pix_en ? hc_q[2:0] : col_q;
      blank_d = pix_en ? (hc_q >= H_VIS || vc_q >= V_VIS) : blank_q;
      hs_d    = pix_en ? !(hc_q >= HS_LO && hc_q <= HS_HI) : hs_q;
      vs_d    = pix_en ? !(vc_q >= VS_LO && vc_q <= VS_HI) : vs_q;
      fs_d    = pix_en ? (hc_q == '0 && vc_q == '0) : fs_q;
   end

   // state registers; reset returns to pixel (0,0) with blanked, inactive-sync outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q   <= '0;
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         hc_q    <= '0;
         vc_q    <= '0;
         data_q  <= '0;
         stb_q   <= 1'b0;
         code_q  <= '0;
         row_q   <= '0;
         col_q   <= '0;
         blank_q <= 1'b1;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         fs_q    <= 1'b0;
      end else begin
         div_q   <= div_d;
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         hc_q    <= hc_d;
         vc_q    <= vc_d;
         data_q  <= data_d;
         stb_q   <= stb_d;
         code_q  <= code_d;
         row_q   <= row_d;
         col_q   <= col_d;
         blank_q <= blank_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         fs_q    <= fs_d;
      end
   end
endmodule
